// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch, multi-cycle multiply, dmem wait.
// Latency: stage controls combinational (same cycle), status registered; backpressure: freezes upstream on wait/multiply.
module pipeline_hazard_ctrl #(
  parameter int MUL_LAT     = 4,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        ex_MemRead,
  input  logic        ex_RegWrite,
  input  logic [4:0]  ex_write_reg_dest,
  input  logic        ex_branch_taken,
  input  logic        ex_mul_start,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_en,
  output logic        id_ex_flush,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        mem_wb_flush,
  output logic        mul_busy,
  output logic        mem_timeout_err,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {S_RUN, S_MUL_BUSY, S_MEM_WAIT} state_t;

  localparam logic       MUL_MULTI  = (MUL_LAT > 1);
  localparam logic [3:0] MUL_RELOAD = (MUL_LAT > 1) ? 4'(MUL_LAT - 2) : 4'd0;
  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  logic [3:0] mul_cnt_q, mul_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mul_done_q;
  logic       mem_wait, mul_start, mul_freeze, freeze, load_use, stall_evt;

  always_comb begin
    mem_wait   = mem_req & ~mem_ready;
    // mul_done_q blocks a restart while the serviced multiply still sits in EX
    mul_start  = (state_q == S_RUN) & ex_mul_start & ~mul_done_q & MUL_MULTI;
    mul_freeze = mul_start | (mul_cnt_q != 4'd0);
    freeze     = mem_wait | mul_freeze;
    load_use   = ex_MemRead & ex_RegWrite & (ex_write_reg_dest != 5'd0) &
                 ((id_uses_rs & (id_rs == ex_write_reg_dest)) |
                  (id_uses_rt & (id_rt == ex_write_reg_dest)));

    mul_cnt_d = 4'd0;
    if (mul_start)
      mul_cnt_d = MUL_RELOAD;
    else if (mul_cnt_q != 4'd0)
      mul_cnt_d = mul_cnt_q - 4'd1;

    state_d = S_RUN;
    if (mem_wait)
      state_d = S_MEM_WAIT;
    else if (mul_cnt_d != 4'd0)
      state_d = S_MUL_BUSY;

    wait_cnt_d = 8'd0;
    if (mem_wait)
      wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;

    stall_evt = freeze | (load_use & ~ex_branch_taken);

    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    mem_wb_flush = 1'b0;
    if (rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_en     = 1'b0;
      id_ex_flush  = 1'b1;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (freeze) begin
      // MEM/WB takes a bubble so the held MEM instruction retires only once
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (load_use) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_flush  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_RUN;
      mul_cnt_q       <= 4'd0;
      wait_cnt_q      <= 8'd0;
      mul_done_q      <= 1'b0;
      mul_busy        <= 1'b0;
      mem_timeout_err <= 1'b0;
      stall_cycles    <= 16'd0;
    end else begin
      state_q    <= state_d;
      mul_cnt_q  <= mul_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      mul_busy   <= (mul_cnt_d != 4'd0);
      if (ex_mem_en)
        mul_done_q <= 1'b0;
      else if (mul_start)
        mul_done_q <= 1'b1;
      if (mem_wait && (wait_cnt_d >= WAIT_LIMIT))
        mem_timeout_err <= 1'b1;
      if (stall_evt && (stall_cycles != 16'hFFFF))
        stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (MUL_LAT=4 and MUL_LAT=1, MEM_TIMEOUT=8) against a cycle-stamped reference model.
module tb_pipeline_hazard_ctrl;
  localparam int TMO = 8;

  typedef struct packed {
    logic pc, ifid, ifid_f, idex, idex_f, exmem, memwb, memwb_f;
  } ctl_t;

  localparam logic [7:0] C_RST    = 8'b0010_1001;
  localparam logic [7:0] C_FREEZE = 8'b0000_0011;
  localparam logic [7:0] C_BRANCH = 8'b1111_1110;
  localparam logic [7:0] C_LU     = 8'b0001_1110;
  localparam logic [7:0] C_NORMAL = 8'b1101_0110;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_write_reg_dest = '0;
  logic id_uses_rs = 0, id_uses_rt = 0, ex_MemRead = 0, ex_RegWrite = 0;
  logic ex_branch_taken = 0, ex_mul_start = 0, mem_req = 0, mem_ready = 0;

  logic [1:0] pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic [1:0] ex_mem_en, mem_wb_en, mem_wb_flush, mul_busy, err;
  logic [15:0] stall0, stall1;

  int vectors = 0;
  int miscompares = 0;

  longint cyc = 0;
  longint m_start[2] = '{-10, -10};
  longint m_end[2]   = '{0, 0};
  bit     prev_wait[2] = '{0, 0};
  bit     serviced[2] = '{0, 0};
  bit     m_err[2] = '{0, 0};
  int     run_len[2] = '{0, 0};
  int     m_stall[2] = '{0, 0};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MUL_LAT(4), .MEM_TIMEOUT(TMO)) u_dut0 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_MemRead(ex_MemRead), .ex_RegWrite(ex_RegWrite),
    .ex_write_reg_dest(ex_write_reg_dest), .ex_branch_taken(ex_branch_taken),
    .ex_mul_start(ex_mul_start), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en[0]), .if_id_en(if_id_en[0]), .if_id_flush(if_id_flush[0]),
    .id_ex_en(id_ex_en[0]), .id_ex_flush(id_ex_flush[0]), .ex_mem_en(ex_mem_en[0]),
    .mem_wb_en(mem_wb_en[0]), .mem_wb_flush(mem_wb_flush[0]),
    .mul_busy(mul_busy[0]), .mem_timeout_err(err[0]), .stall_cycles(stall0)
  );

  pipeline_hazard_ctrl #(.MUL_LAT(1), .MEM_TIMEOUT(TMO)) u_dut1 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_MemRead(ex_MemRead), .ex_RegWrite(ex_RegWrite),
    .ex_write_reg_dest(ex_write_reg_dest), .ex_branch_taken(ex_branch_taken),
    .ex_mul_start(ex_mul_start), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en[1]), .if_id_en(if_id_en[1]), .if_id_flush(if_id_flush[1]),
    .id_ex_en(id_ex_en[1]), .id_ex_flush(id_ex_flush[1]), .ex_mem_en(ex_mem_en[1]),
    .mem_wb_en(mem_wb_en[1]), .mem_wb_flush(mem_wb_flush[1]),
    .mul_busy(mul_busy[1]), .mem_timeout_err(err[1]), .stall_cycles(stall1)
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic logic [7:0] act_ctl(input int k);
    return {pc_en[k], if_id_en[k], if_id_flush[k], id_ex_en[k],
            id_ex_flush[k], ex_mem_en[k], mem_wb_en[k], mem_wb_flush[k]};
  endfunction

  function automatic logic [15:0] act_stall(input int k);
    return (k == 0) ? stall0 : stall1;
  endfunction

  // Reference: a multiply starting in cycle s freezes cycles s .. s+MUL_LAT-2.
  function automatic void model_eval(input int k, output ctl_t c, output bit frz,
                                     output bit lu_eff, output bit start);
    bit mw, mul_act, run, lu;
    mw      = mem_req && !mem_ready;
    mul_act = cyc < m_end[k];
    run     = !prev_wait[k] && !mul_act;
    start   = run && ex_mul_start && !serviced[k] && (lat_of(k) > 1);
    frz     = mw || mul_act || start;
    lu      = ex_MemRead && ex_RegWrite && (ex_write_reg_dest != 0) &&
              ((id_uses_rs && id_rs == ex_write_reg_dest) ||
               (id_uses_rt && id_rt == ex_write_reg_dest));
    lu_eff  = !rst && !frz && !ex_branch_taken && lu;
    if (rst)                  c = C_RST;
    else if (frz)             c = C_FREEZE;
    else if (ex_branch_taken) c = C_BRANCH;
    else if (lu)              c = C_LU;
    else                      c = C_NORMAL;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d cycle %0d: got 0x%0h, expected 0x%0h", name, k, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    ctl_t c;
    bit frz, lue, st;
    for (int k = 0; k < 2; k++) begin
      model_eval(k, c, frz, lue, st);
      if (rst) begin
        m_start[k] = -10; m_end[k] = 0; prev_wait[k] = 0; serviced[k] = 0;
        run_len[k] = 0; m_err[k] = 0; m_stall[k] = 0;
      end else begin
        if (st) begin
          m_start[k] = cyc;
          m_end[k]   = cyc + lat_of(k) - 1;
        end
        if (c.exmem) serviced[k] = 0;
        else if (st) serviced[k] = 1;
        prev_wait[k] = mem_req && !mem_ready;
        run_len[k]   = prev_wait[k] ? run_len[k] + 1 : 0;
        if (run_len[k] >= TMO) m_err[k] = 1;
        if ((frz || lue) && m_stall[k] < 65535) m_stall[k]++;
      end
    end
    cyc++;
  endtask

  task automatic model_compare();
    ctl_t c;
    bit frz, lue, st;
    for (int k = 0; k < 2; k++) begin
      model_eval(k, c, frz, lue, st);
      chk("ctl", k, 32'(act_ctl(k)), 32'(c));
      chk("mul_busy", k, 32'(mul_busy[k]), 32'(cyc > m_start[k] && cyc < m_end[k]));
      chk("timeout_err", k, 32'(err[k]), 32'(m_err[k]));
      chk("stall_cycles", k, 32'(act_stall(k)), 32'(m_stall[k]));
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    model_compare();
  end

  task automatic nc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    ex_MemRead = 0; ex_RegWrite = 0; ex_write_reg_dest = 0;
    ex_branch_taken = 0; ex_mul_start = 0; mem_req = 0; mem_ready = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    nc(); nc();
    mid();
    chk("rst_pc_en", 0, 32'(pc_en[0]), 0);
    chk("rst_ctl", 0, 32'(act_ctl(0)), 32'(C_RST));
    chk("rst_stall", 0, 32'(stall0), 0);
    nc(); rst = 0;

    // load-use: lw r5 in EX, ID reads r5
    ex_MemRead = 1; ex_RegWrite = 1; ex_write_reg_dest = 5; id_rs = 5; id_uses_rs = 1;
    mid();
    chk("lu_ctl", 0, 32'(act_ctl(0)), 32'(C_LU));
    nc(); idle();
    mid();
    chk("lu_stall", 0, 32'(stall0), 1);
    chk("lu_done_pc_en", 0, 32'(pc_en[0]), 1);

    // dest r0 never hazards
    nc();
    ex_MemRead = 1; ex_RegWrite = 1; ex_write_reg_dest = 0; id_rs = 0; id_uses_rs = 1;
    mid();
    chk("r0_pc_en", 0, 32'(pc_en[0]), 1);

    // branch together with load-use match
    nc(); idle();
    ex_MemRead = 1; ex_RegWrite = 1; ex_write_reg_dest = 7; id_rt = 7; id_uses_rt = 1;
    ex_branch_taken = 1;
    mid();
    chk("br_lu_ctl", 0, 32'(act_ctl(0)), 32'(C_BRANCH));
    nc(); idle();
    mid();
    chk("br_stall", 0, 32'(stall0), 1);

    // multiply, MUL_LAT=4 vs MUL_LAT=1
    nc(); ex_mul_start = 1;
    mid();
    chk("mul_f1_ctl", 0, 32'(act_ctl(0)), 32'(C_FREEZE));
    chk("mul_f1_busy", 0, 32'(mul_busy[0]), 0);
    chk("mul_lat1_pc_en", 1, 32'(pc_en[1]), 1);
    nc(); mid();
    chk("mul_f2_busy", 0, 32'(mul_busy[0]), 1);
    nc(); mid();
    chk("mul_f3_busy", 0, 32'(mul_busy[0]), 1);
    chk("mul_f3_pc_en", 0, 32'(pc_en[0]), 0);
    nc(); mid();
    chk("mul_release_ctl", 0, 32'(act_ctl(0)), 32'(C_NORMAL));
    chk("mul_release_busy", 0, 32'(mul_busy[0]), 0);
    nc(); idle(); mid();
    chk("mul_stall", 0, 32'(stall0), 4);

    // memory wait of 5 cycles
    nc(); mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 5; i++) begin
      mid();
      chk("memwait_pc_en", 0, 32'(pc_en[0]), 0);
      nc();
    end
    mem_ready = 1;
    mid();
    chk("memwait_release", 0, 32'(act_ctl(0)), 32'(C_NORMAL));
    nc(); idle(); mid();
    chk("memwait_stall", 0, 32'(stall0), 9);

    // short memory wait inside a multiply: multiply still holds the freeze
    nc(); ex_mul_start = 1;
    mid();
    nc(); mem_req = 1; mem_ready = 0;
    mid();
    nc(); mem_ready = 1;
    mid();
    chk("ovl1_mul_holds", 0, 32'(pc_en[0]), 0);
    nc(); mem_req = 0; mem_ready = 0;
    mid();
    chk("ovl1_release", 0, 32'(pc_en[0]), 1);
    nc(); idle();

    // long memory wait outlasting a multiply
    nc(); ex_mul_start = 1;
    mid();
    nc(); mem_req = 1; mem_ready = 0;
    mid();
    nc(); mid();
    chk("ovl2_busy_c", 0, 32'(mul_busy[0]), 1);
    nc(); mid();
    chk("ovl2_busy_d", 0, 32'(mul_busy[0]), 0);
    chk("ovl2_pc_en_d", 0, 32'(pc_en[0]), 0);
    nc(); mid();
    chk("ovl2_pc_en_e", 0, 32'(pc_en[0]), 0);
    nc(); mem_ready = 1;
    mid();
    chk("ovl2_release", 0, 32'(pc_en[0]), 1);
    nc(); idle(); mid();
    chk("ovl_stall", 0, 32'(stall0), 17);

    // timeout after 8 wait cycles, sticky until reset
    nc(); mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 8; i++) begin
      mid();
      chk("tmo_not_yet", 0, 32'(err[0]), 0);
      nc();
    end
    mid();
    chk("tmo_set", 0, 32'(err[0]), 1);
    nc(); mem_ready = 1;
    mid();
    chk("tmo_sticky_ready", 0, 32'(err[0]), 1);
    nc(); idle(); mid();
    chk("tmo_sticky_idle", 0, 32'(err[0]), 1);
    nc(); rst = 1;
    nc(); mid();
    chk("tmo_cleared", 0, 32'(err[0]), 0);

    // reset during the second freeze cycle of a multiply
    nc(); rst = 0; idle(); ex_mul_start = 1;
    mid();
    chk("rmul_f1", 0, 32'(pc_en[0]), 0);
    nc(); rst = 1;
    mid();
    chk("rmul_rst_ctl", 0, 32'(act_ctl(0)), 32'(C_RST));
    nc(); ex_mul_start = 0;
    mid();
    chk("rmul_busy", 0, 32'(mul_busy[0]), 0);
    chk("rmul_stall", 0, 32'(stall0), 0);
    nc(); rst = 0;
    mid();
    chk("rmul_after_ctl", 0, 32'(act_ctl(0)), 32'(C_NORMAL));
    nc(); mid();
    chk("rmul_after_stall", 0, 32'(stall0), 0);

    // randomized traffic, checked each cycle by the model
    for (int i = 0; i < 3000; i++) begin
      nc();
      rst               = ($urandom_range(0, 199) == 0);
      mem_req           = ($urandom_range(0, 3) == 0);
      mem_ready         = ($urandom_range(0, 1) == 1);
      ex_mul_start      = ex_mul_start ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
      ex_branch_taken   = ($urandom_range(0, 7) == 0);
      ex_MemRead        = ($urandom_range(0, 2) == 0);
      ex_RegWrite       = ($urandom_range(0, 1) == 1);
      ex_write_reg_dest = 5'($urandom_range(0, 3));
      id_rs             = 5'($urandom_range(0, 3));
      id_rt             = 5'($urandom_range(0, 3));
      id_uses_rs        = ($urandom_range(0, 1) == 1);
      id_uses_rt        = ($urandom_range(0, 1) == 1);
    end
    nc();
    mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline. Drives the load-enable and bubble-insert controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves four hazard types:
  - load-use hazards;
  - taken-branch flushes;
  - multi-cycle multiply occupancy of EX;
  - data-memory wait states.
- Also keeps a stall-cycle performance counter.
- State is registered. Stage controls are combinational from current state plus inputs, so they apply in the same cycle.

Parameters:
- MUL_LAT, 4: total EX cycles for a multiply, including the start cycle; legal range 1-15.
- MEM_TIMEOUT, 255: maximum consecutive memory-wait cycles before the error flag is set; legal range 1-255.

Ports:
- clk  input  1  pipeline clock; all registers update on posedge.
- rst  input  1  synchronous, active-high reset.
- id_rs  input  5  source register 1 of the instruction in ID.
- id_rt  input  5  source register 2 of the instruction in ID.
- id_uses_rs  input  1  ID instruction reads rs.
- id_uses_rt  input  1  ID instruction reads rt.
- ex_MemRead  input  1  the instruction in EX is a load.
- ex_RegWrite  input  1  the instruction in EX writes the register file.
- ex_write_reg_dest  input  5  destination register of the instruction in EX.
- ex_branch_taken  input  1  the branch in EX resolved taken.
- ex_mul_start  input  1  the instruction in EX is a multiply; held high while EX is frozen.
- mem_req  input  1  MEM stage has a data-memory access pending.
- mem_ready  input  1  data memory completes the access this cycle.
- pc_en  output  1  PC load enable.
- if_id_en  output  1  IF/ID load enable.
- if_id_flush  output  1  IF/ID loads a bubble.
- id_ex_en  output  1  ID/EX load enable.
- id_ex_flush  output  1  ID/EX loads a bubble (RegWrite=0, MemRead=0).
- ex_mem_en  output  1  EX/MEM load enable.
- mem_wb_en  output  1  MEM/WB load enable.
- mem_wb_flush  output  1  MEM/WB loads a bubble (RegWrite=0).
- mul_busy  output  1  registered; multiply in progress.
- mem_timeout_err  output  1  registered; sticky error flag.
- stall_cycles  output  16  registered; saturating count of freeze and load-use cycles.

Behaviour:
- Reset: while rst=1:
  - All *_en outputs = 0; if_id_flush, id_ex_flush and mem_wb_flush = 1.
  - mul_busy=0, mem_timeout_err=0, stall_cycles=0, FSM=RUN.
  - After reset releases, the FSM starts in RUN.
  - Reset asserted mid-stall aborts the stall; no partial count survives.
- FSM states:
  - RUN → MUL_BUSY when ex_mul_start=1 and MUL_LAT>1.
  - Any state → MEM_WAIT when mem_req=1 and mem_ready=0; this takes priority over the transition to MUL_BUSY.
  - MEM_WAIT → MUL_BUSY if the multiply counter is still nonzero when mem_ready=1.
  - MEM_WAIT → RUN otherwise.
  - MUL_BUSY → RUN when the counter expires and no memory wait is active.
- Freeze (memory wait, or multiply not yet complete):
  - pc_en, if_id_en, id_ex_en and ex_mem_en = 0.
  - mem_wb_en=1 with mem_wb_flush=1, so the held MEM instruction is not written back twice.
  - if_id_flush=0 and id_ex_flush=0.
- Memory wait: freeze is asserted in the same cycle that mem_req=1 and mem_ready=0, and released in the cycle mem_ready=1.
  - A wait-cycle counter resets whenever the block is not waiting.
  - When the counter reaches MEM_TIMEOUT, set mem_timeout_err, which stays set until rst.
  - Stalling continues after the error is set.
- Multiply: upstream stages are frozen for exactly MUL_LAT-1 consecutive cycles, starting with the cycle ex_mul_start first rises in RUN.
  - The following cycle is the release cycle: all enables = 1 and no flush.
  - ex_mul_start is ignored while mul_busy=1.
  - The multiply counter keeps decrementing during an overlapping memory wait.
  - Release requires both the multiply and the memory wait to be done.
  - MUL_LAT=1 produces no stall.
  - mul_busy=1 from the cycle after the start through the last frozen cycle.
- Branch (no freeze active): if ex_branch_taken=1:
  - pc_en=1, if_id_flush=1, id_ex_flush=1, all enables = 1.
  - A load-use hazard in the same cycle is ignored, because the ID instruction is being squashed.
- Load-use (no freeze, no branch): triggers when all of the following hold:
  - ex_MemRead=1, ex_RegWrite=1 and ex_write_reg_dest≠0;
  - (id_uses_rs and id_rs==dest) or (id_uses_rt and id_rt==dest).
  - Response: pc_en=0, if_id_en=0, id_ex_en=1 with id_ex_flush=1, ex_mem_en=1, mem_wb_en=1. This lasts one cycle.
- Priority: rst > freeze > branch > load-use > normal.
- Normal: all enables = 1, all flushes = 0.
- A branch or load-use condition that arrives during a freeze is evaluated after release, because the stages hold their contents.
- stall_cycles: increments by 1 on every freeze cycle and every load-use cycle; saturates at 0xFFFF and does not wrap.

Test Plan:
- Load-use: lw writes r5, followed by add reading r5 in rs → exactly 1 cycle of pc_en=0, if_id_en=0, id_ex_flush=1; stall_cycles=1. Repeat with dest=r0 → no stall.
- Branch and load-use in the same cycle: ex_branch_taken=1 together with a load-use match → if_id_flush=1, id_ex_flush=1, pc_en=1; no stall.
- Multiply, MUL_LAT=4: ex_mul_start held high → 3 freeze cycles with mem_wb_flush=1, then release with all enables = 1; mul_busy high for 2 cycles; stall_cycles=3. With MUL_LAT=1 → no freeze.
- Memory wait: mem_req=1 with mem_ready=0 for 5 cycles, then mem_ready=1 → freeze for 5 cycles, release in the 6th. Overlap with a MUL_LAT=4 multiply → release only when both are done.
- Timeout: MEM_TIMEOUT=8, mem_ready held at 0 → mem_timeout_err rises after 8 wait cycles and stays set after mem_ready=1; cleared only by rst.
- Reset mid-multiply: assert rst during the 2nd freeze cycle → enables = 0, flushes = 1, mul_busy=0, stall_cycles=0. After release the pipeline runs normally with no residual stall.
